clkgen_multi: RTL and testbench

Multi-channel programmable clock-enable/clock divider, the parametrised successor to the fixed single-output divider. It derives NCH independent square waves from clkin, each with a half-period set at runtime through a simple write port. New values are applied glitch-free at period boundaries, and each channel reports a one-cycle rising-edge tick. It sits beside the system clock and feeds scan, blink, UART-baud and display-refresh logic.

---
 rtl/clkgen_multi.sv | 99 +++++++++
 tb/tb_clkgen_multi.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_multi.sv
// Multi-channel programmable clock divider with glitch-free shadowed limit updates.
// Optional CLKGEN_DUTY_EN: independent low-phase length (wr_lo); otherwise 50% duty.
module clkgen_multi #(
  parameter int CLK_FREQ_IN = 50000000,
  parameter int DEF_FREQ    = 1000,
  parameter int NCH         = 4,
  parameter int CNT_W       = 32,
  parameter int SEL_W       = 2
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             clken,
  input  logic [NCH-1:0]   ch_en,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [CNT_W-1:0] wr_hi,
  input  logic [CNT_W-1:0] wr_lo,
  output logic [NCH-1:0]   clkout,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pending
);

  localparam int DEF_HALF_I = CLK_FREQ_IN / 2 / DEF_FREQ;
  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEF_HALF_I);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

`ifndef CLKGEN_DUTY_EN
  logic unused_wr_lo;
  assign unused_wr_lo = ^wr_lo;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, act_hi, sh_hi;
    logic [CNT_W-1:0] hi_eff, lo_eff, lim;
    logic             clk_q, tick_q, pend_q;
    logic             en, tgl, fall, apply, wr_hit;

    // A programmed limit of zero behaves like one: toggle every enabled cycle.
    assign hi_eff = (act_hi == '0) ? ONE : act_hi;

`ifdef CLKGEN_DUTY_EN
    logic [CNT_W-1:0] act_lo, sh_lo;

    assign lo_eff = (act_lo == '0) ? ONE : act_lo;

    always_ff @(posedge clkin) begin
      if (rst) begin
        act_lo <= DEF_HALF;
        sh_lo  <= DEF_HALF;
      end else begin
        if (apply)  act_lo <= sh_lo;
        if (wr_hit) sh_lo  <= wr_lo;
      end
    end
`else
    assign lo_eff = hi_eff;
`endif

    assign lim    = clk_q ? hi_eff : lo_eff;
    assign en     = clken & ch_en[i];
    assign tgl    = en && (cnt >= lim - ONE);
    assign fall   = tgl && clk_q;
    // Apply at end of a full period, or immediately while frozen (no waveform to glitch).
    assign apply  = pend_q && (fall || !en);
    assign wr_hit = wr_en && (wr_sel == SEL_W'(i));

    always_ff @(posedge clkin) begin
      if (rst) begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
        act_hi <= DEF_HALF;
        sh_hi  <= DEF_HALF;
      end else begin
        tick_q <= tgl && !clk_q;
        if (tgl) begin
          cnt   <= '0;
          clk_q <= ~clk_q;
        end else if (en) begin
          cnt <= cnt + ONE;
        end
        if (apply) act_hi <= sh_hi;
        // A write in the apply cycle lands in the shadow and stays pending.
        if (wr_hit) begin
          sh_hi  <= wr_hi;
          pend_q <= 1'b1;
        end else if (apply) begin
          pend_q <= 1'b0;
        end
      end
    end

    assign clkout[i]  = clk_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi with DEF_HALF=5 (CLK_FREQ_IN=1000, DEF_FREQ=100).
module tb_clkgen_multi;

  localparam int NCH   = 4;
  localparam int CNT_W = 32;
  localparam int SEL_W = 2;

  logic             clkin = 1'b0;
  logic             rst;
  logic             clken;
  logic [NCH-1:0]   ch_en;
  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic [CNT_W-1:0] wr_hi;
  logic [CNT_W-1:0] wr_lo;
  logic [NCH-1:0]   clkout;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pending;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  clkgen_multi #(
    .CLK_FREQ_IN(1000),
    .DEF_FREQ   (100),
    .NCH        (NCH),
    .CNT_W      (CNT_W),
    .SEL_W      (SEL_W)
  ) dut (
    .clkin  (clkin),
    .rst    (rst),
    .clken  (clken),
    .ch_en  (ch_en),
    .wr_en  (wr_en),
    .wr_sel (wr_sel),
    .wr_hi  (wr_hi),
    .wr_lo  (wr_lo),
    .clkout (clkout),
    .tick   (tick),
    .pending(pending)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Default 5/5 waveform: first rise at cycle 5 after reset release.
  function automatic logic def_wave(input int k);
    return ((k / 5) % 2) == 1;
  endfunction

  task automatic step();
    @(posedge clkin);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check("rst_clkout",  32'(clkout),  32'h0);
    check("rst_tick",    32'(tick),    32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic do_write(input int sel, input int hi, input int lo);
    wr_en  = 1'b1;
    wr_sel = SEL_W'(sel);
    wr_hi  = CNT_W'(hi);
    wr_lo  = CNT_W'(lo);
    step();
    wr_en  = 1'b0;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  logic [13:0] exp_ch1_t2;
  logic        e;

  initial begin
    rst = 1'b1; clken = 1'b1; ch_en = '1; wr_en = 1'b0;
    wr_sel = '0; wr_hi = '0; wr_lo = '0;

    // Default waveform on all channels
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step();
      check("def_clkout",  32'(clkout),  {28'h0, {4{def_wave(k)}}});
      check("def_tick",    32'(tick),    (k == 5 || k == 15) ? 32'hF : 32'h0);
      check("def_pending", 32'(pending), 32'h0);
    end

    // ch1 rewritten to 3 during a high phase; applied at the following fall
    do_reset();
    run_to(26);
    do_write(1, 3, 0);
    check("t2_pending_set", 32'(pending), 32'h2);
    exp_ch1_t2 = 14'b11100011100011;
    for (int k = 28; k <= 41; k++) begin
      step();
      check("t2_ch1",    32'(clkout[1]), 32'(exp_ch1_t2[k-28]));
      check("t2_ch1_tk", 32'(tick[1]),   32'(k == 33 || k == 39));
      check("t2_others", 32'({clkout[3:2], clkout[0]}), {29'h0, {3{def_wave(k)}}});
      check("t2_pend",   32'(pending),   (k < 30) ? 32'h2 : 32'h0);
    end

    // ch0 limit 0 -> toggles every enabled cycle after apply
    do_reset();
    do_write(0, 0, 0);
    check("t3_pending_set", 32'(pending), 32'h1);
    for (int k = 2; k <= 16; k++) begin
      step();
      e = (k < 10) ? def_wave(k) : (k % 2 == 1);
      check("t3_ch0",    32'(clkout[0]),  32'(e));
      check("t3_ch0_tk", 32'(tick[0]),    32'(k == 5 || (k >= 11 && k % 2 == 1)));
      check("t3_pend",   32'(pending[0]), 32'(k < 10));
    end

    // ch2 frozen for 7 cycles in its high phase
    do_reset();
    run_to(7);
    ch_en = 4'b1011;
    for (int k = 8; k <= 14; k++) begin
      step();
      check("t4_hold_ch2", 32'(clkout[2]), 32'h1);
      check("t4_hold_tk",  32'(tick[2]),   32'h0);
    end
    ch_en = '1;
    for (int k = 15; k <= 23; k++) begin
      step();
      check("t4_ch2",    32'(clkout[2]), 32'(k < 17 || k >= 22));
      check("t4_ch2_tk", 32'(tick[2]),   32'(k == 22));
      check("t4_ch0",    32'(clkout[0]), 32'(def_wave(k)));
      check("t4_pend",   32'(pending),   32'h0);
    end

    // Write while globally disabled: applied next cycle; cnt already past new limit
    do_reset();
    run_to(3);
    clken = 1'b0;
    do_write(3, 2, 0);
    check("t5_pend_set", 32'(pending), 32'h8);
    check("t5_hold",     32'(clkout),  32'h0);
    step();
    check("t5_pend_clr", 32'(pending), 32'h0);
    check("t5_hold2",    32'(clkout),  32'h0);
    clken = 1'b1;
    for (int k = 6; k <= 12; k++) begin
      step();
      check("t5_ch3", 32'(clkout[3]), 32'(k == 6 || k == 7 || k == 10 || k == 11));
      check("t5_ch0", 32'(clkout[0]), 32'(k >= 7 && k <= 11));
    end

    // hi=2 lo=6 on ch1: 2/6 with duty support, 2/2 without
    do_reset();
    clken = 1'b0;
    do_write(1, 2, 6);
    check("t6_pend_set", 32'(pending), 32'h2);
    step();
    check("t6_pend_clr", 32'(pending), 32'h0);
    clken = 1'b1;
    for (int k = 3; k <= 17; k++) begin
      step();
`ifdef CLKGEN_DUTY_EN
      e = (k == 8 || k == 9 || k == 16 || k == 17);
`else
      e = (k >= 4) && (((k - 4) / 2) % 2 == 0);
`endif
      check("t6_ch1", 32'(clkout[1]), 32'(e));
    end

    // Reset mid-phase discards a pending write and restarts the default waveform
    do_reset();
    run_to(6);
    do_write(0, 3, 0);
    check("t7_pend_set", 32'(pending), 32'h1);
    rst = 1'b1;
    step();
    check("t7_clkout",  32'(clkout),  32'h0);
    check("t7_tick",    32'(tick),    32'h0);
    check("t7_pending", 32'(pending), 32'h0);
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("t7_wave", 32'(clkout),  {28'h0, {4{def_wave(k)}}});
      check("t7_tk",   32'(tick),    (k == 5) ? 32'hF : 32'h0);
      check("t7_pend", 32'(pending), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
